idex_stage: RTL and testbench

ID/EX pipeline register and execute-stage operand forwarding for the pipelined RV32I core. It captures decoded operands and controls at the end of Decode and resolves RAW hazards against the Memory and Writeback stages. It drives SrcAE, SrcBE and ALUControlE directly into the execute-stage ALU. Stall and flush come from the hazard unit; forwarding selects are computed here.

---
 rtl/idex_stage.sv | 157 +++++++++++++++
 tb/tb_idex_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register with execute-stage operand forwarding from M and W.
// Define IDEX_FWD_EN to build the forwarding selects; otherwise they are tied to 00.
module idex_stage #(
  parameter int XLEN    = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    ImmExtD,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic [REGBITS-1:0] Rs1D,
  input  logic [REGBITS-1:0] Rs2D,
  input  logic [REGBITS-1:0] RdD,
  input  logic [3:0]         ALUControlD,
  input  logic               ALUSrcD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               JumpD,
  input  logic               BranchD,
  input  logic [1:0]         ResultSrcD,
  input  logic [XLEN-1:0]    ALUResultM,
  input  logic [REGBITS-1:0] RdM,
  input  logic               RegWriteM,
  input  logic [XLEN-1:0]    ResultW,
  input  logic [REGBITS-1:0] RdW,
  input  logic               RegWriteW,
  output logic [XLEN-1:0]    SrcAE,
  output logic [XLEN-1:0]    SrcBE,
  output logic [3:0]         ALUControlE,
  output logic [XLEN-1:0]    WriteDataE,
  output logic [XLEN-1:0]    ImmExtE,
  output logic [XLEN-1:0]    PCE,
  output logic [XLEN-1:0]    PCPlus4E,
  output logic [REGBITS-1:0] Rs1E,
  output logic [REGBITS-1:0] Rs2E,
  output logic [REGBITS-1:0] RdE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               JumpE,
  output logic               BranchE,
  output logic [1:0]         ResultSrcE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE
);

  logic [XLEN-1:0]    r_rd1, r_rd2, r_imm, r_pc, r_pcp4;
  logic [REGBITS-1:0] r_rs1, r_rs2, r_rd;
  logic [3:0]         r_aluctl;
  logic               r_alusrc, r_regwrite, r_memwrite, r_jump, r_branch;
  logic [1:0]         r_resultsrc;

  logic [1:0]         w_fwd_a, w_fwd_b;
  logic [XLEN-1:0]    w_src_a, w_wdata;

  // Clearing every register on flush yields an add with no side effects: a bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_pcp4      <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_aluctl    <= '0;
      r_alusrc    <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_jump      <= 1'b0;
      r_branch    <= 1'b0;
      r_resultsrc <= '0;
    end else if (!StallE) begin
      r_rd1       <= RD1D;
      r_rd2       <= RD2D;
      r_imm       <= ImmExtD;
      r_pc        <= PCD;
      r_pcp4      <= PCPlus4D;
      r_rs1       <= Rs1D;
      r_rs2       <= Rs2D;
      r_rd        <= RdD;
      r_aluctl    <= ALUControlD;
      r_alusrc    <= ALUSrcD;
      r_regwrite  <= RegWriteD;
      r_memwrite  <= MemWriteD;
      r_jump      <= JumpD;
      r_branch    <= BranchD;
      r_resultsrc <= ResultSrcD;
    end
  end

`ifdef IDEX_FWD_EN
  // Memory stage is checked first since it carries the younger result.
  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == r_rs1))
      w_fwd_a = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == r_rs1))
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == r_rs2))
      w_fwd_b = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == r_rs2))
      w_fwd_b = 2'b01;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{RdM, RegWriteM, RdW, RegWriteW};
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
`endif

  always_comb begin
    w_src_a = r_rd1;
    case (w_fwd_a)
      2'b10:   w_src_a = ALUResultM;
      2'b01:   w_src_a = ResultW;
      default: w_src_a = r_rd1;
    endcase
  end

  always_comb begin
    w_wdata = r_rd2;
    case (w_fwd_b)
      2'b10:   w_wdata = ALUResultM;
      2'b01:   w_wdata = ResultW;
      default: w_wdata = r_rd2;
    endcase
  end

  assign SrcAE       = w_src_a;
  assign WriteDataE  = w_wdata;
  assign SrcBE       = r_alusrc ? r_imm : w_wdata;
  assign ForwardAE   = w_fwd_a;
  assign ForwardBE   = w_fwd_b;
  assign ALUControlE = r_aluctl;
  assign ImmExtE     = r_imm;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pcp4;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign RegWriteE   = r_regwrite;
  assign MemWriteE   = r_memwrite;
  assign JumpE       = r_jump;
  assign BranchE     = r_branch;
  assign ResultSrcE  = r_resultsrc;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: expected E state is queued at each drive and
// compared after the capturing edge; forwarding is checked against a reference model.
module tb_idex_stage;

  localparam int XLEN = 32;
  localparam int RB   = 5;

  logic            clk = 1'b0;
  logic            reset, StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [RB-1:0]   Rs1D, Rs2D, RdD;
  logic [3:0]      ALUControlD;
  logic            ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD;
  logic [1:0]      ResultSrcD;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic [RB-1:0]   RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, PCPlus4E;
  logic [3:0]      ALUControlE;
  logic [RB-1:0]   Rs1E, Rs2E, RdE;
  logic            RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;

  always #5 clk = ~clk;

  idex_stage #(.XLEN(XLEN), .REGBITS(RB)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  typedef struct {
    logic [XLEN-1:0] rd1, rd2, imm, pc, pcp4;
    logic [RB-1:0]   rs1, rs2, rd;
    logic [3:0]      aluc;
    logic            alusrc, regw, memw, jump, branch;
    logic [1:0]      rsrc;
  } e_state_t;

  e_state_t m_e, cur_e;
  e_state_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [RB-1:0] rs);
`ifdef IDEX_FWD_EN
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [XLEN-1:0] fwd_val(input logic [1:0] sel, input logic [XLEN-1:0] regv);
    if (sel == 2'b10) return ALUResultM;
    if (sel == 2'b01) return ResultW;
    return regv;
  endfunction

  // One capturing edge: model the next E state, queue it, then compare after the edge.
  task automatic step(input logic st, input logic fl, input logic rs);
    e_state_t nxt;
    @(negedge clk);
    StallE = st; FlushE = fl; reset = rs;
    if (rs || fl) begin
      nxt = '{default: '0};
    end else if (st) begin
      nxt = m_e;
    end else begin
      nxt.rd1 = RD1D; nxt.rd2 = RD2D; nxt.imm = ImmExtD; nxt.pc = PCD; nxt.pcp4 = PCPlus4D;
      nxt.rs1 = Rs1D; nxt.rs2 = Rs2D; nxt.rd = RdD; nxt.aluc = ALUControlD;
      nxt.alusrc = ALUSrcD; nxt.regw = RegWriteD; nxt.memw = MemWriteD;
      nxt.jump = JumpD; nxt.branch = BranchD; nxt.rsrc = ResultSrcD;
    end
    m_e = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    cur_e = exp_q.pop_front();
    check_val("ALUControlE", {28'd0, ALUControlE}, {28'd0, cur_e.aluc});
    check_val("ImmExtE", ImmExtE, cur_e.imm);
    check_val("PCE", PCE, cur_e.pc);
    check_val("PCPlus4E", PCPlus4E, cur_e.pcp4);
    check_val("Rs1E", {27'd0, Rs1E}, {27'd0, cur_e.rs1});
    check_val("Rs2E", {27'd0, Rs2E}, {27'd0, cur_e.rs2});
    check_val("RdE", {27'd0, RdE}, {27'd0, cur_e.rd});
    check_val("ctrl", {27'd0, RegWriteE, MemWriteE, JumpE, BranchE, 1'b0},
              {27'd0, cur_e.regw, cur_e.memw, cur_e.jump, cur_e.branch, 1'b0});
    check_val("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, cur_e.rsrc});
  endtask

  task automatic check_comb(input string tag);
    logic [1:0]      fa, fb;
    logic [XLEN-1:0] wd;
    #1;
    fa = fwd_sel(cur_e.rs1);
    fb = fwd_sel(cur_e.rs2);
    wd = fwd_val(fb, cur_e.rd2);
    check_val({tag, ".ForwardAE"}, {30'd0, ForwardAE}, {30'd0, fa});
    check_val({tag, ".ForwardBE"}, {30'd0, ForwardBE}, {30'd0, fb});
    check_val({tag, ".SrcAE"}, SrcAE, fwd_val(fa, cur_e.rd1));
    check_val({tag, ".WriteDataE"}, WriteDataE, wd);
    check_val({tag, ".SrcBE"}, SrcBE, cur_e.alusrc ? cur_e.imm : wd);
  endtask

  task automatic set_mw(input logic [RB-1:0] rdm, input logic rwm, input logic [XLEN-1:0] am,
                        input logic [RB-1:0] rdw, input logic rww, input logic [XLEN-1:0] rw);
    RdM = rdm; RegWriteM = rwm; ALUResultM = am;
    RdW = rdw; RegWriteW = rww; ResultW = rw;
  endtask

  task automatic rand_d();
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    Rs1D = RB'($urandom_range(0, 3)); Rs2D = RB'($urandom_range(0, 3)); RdD = RB'($urandom);
    ALUControlD = 4'($urandom); ALUSrcD = 1'($urandom); RegWriteD = 1'($urandom);
    MemWriteD = 1'($urandom); JumpD = 1'($urandom); BranchD = 1'($urandom);
    ResultSrcD = 2'($urandom);
  endtask

  initial begin
    m_e = '{default: '0};
    cur_e = '{default: '0};
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    set_mw(0, 0, 0, 0, 0, 0);
    RD1D = '1; RD2D = '1; ImmExtD = '1; PCD = '1; PCPlus4D = '1;
    Rs1D = '1; Rs2D = '1; RdD = '1; ALUControlD = '1; ALUSrcD = 1'b1;
    RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1; ResultSrcD = '1;

    // Reset with every D input high: all E outputs read zero.
    step(1'b0, 1'b0, 1'b1);
    check_comb("reset");
    check_val("reset.SrcAE_zero", SrcAE, 32'd0);

    // Plain load, immediate selected for SrcB.
    RD1D = 32'd5; RD2D = 32'd7; ImmExtD = 32'h10; ALUSrcD = 1'b1;
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd9; ALUControlD = 4'd2;
    PCD = 32'h100; PCPlus4D = 32'h104; RegWriteD = 1'b1; MemWriteD = 1'b0;
    JumpD = 1'b0; BranchD = 1'b0; ResultSrcD = 2'b01;
    step(1'b0, 1'b0, 1'b0);
    check_comb("load");
    check_val("load.SrcAE_lit", SrcAE, 32'd5);
    check_val("load.SrcBE_lit", SrcBE, 32'h10);
    check_val("load.WD_lit", WriteDataE, 32'd7);

    // Both M and W target rs1: M wins; then W alone.
    set_mw(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
    check_comb("fwd_mw");
    set_mw(5'd3, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB);
    check_comb("fwd_w");

    // x0 destination is never forwarded.
    Rs2D = 5'd0; RD2D = 32'd0; ALUSrcD = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    set_mw(5'd0, 1'b1, 32'h55, 5'd0, 1'b1, 32'h66);
    check_comb("x0");

    // Stall holds E registers while forwarding keeps tracking M/W.
    rand_d();
    step(1'b1, 1'b0, 1'b0);
    set_mw(cur_e.rs1, 1'b1, 32'h1234, cur_e.rs2, 1'b1, 32'h5678);
    check_comb("stall_a");
    rand_d();
    step(1'b1, 1'b0, 1'b0);
    set_mw(5'd0, 1'b0, 32'h0, cur_e.rs1, 1'b1, 32'h9ABC);
    check_comb("stall_b");

    // Flush beats stall.
    rand_d();
    step(1'b1, 1'b1, 1'b0);
    check_comb("flush_stall");

    // Reset mid-stream beats stall and flush.
    rand_d();
    step(1'b0, 1'b0, 1'b0);
    rand_d();
    step(1'b1, 1'b1, 1'b1);
    check_comb("reset_mid");

    // Randomized mix of loads, stalls, flushes and forwarding patterns.
    for (int i = 0; i < 60; i++) begin
      rand_d();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      set_mw(RB'($urandom_range(0, 3)), 1'($urandom), $urandom,
             RB'($urandom_range(0, 3)), 1'($urandom), $urandom);
      check_comb("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
